// File: rtl/serializador_param.sv
// Parallel-to-serial converter: loads an N-bit word and presents it one bit at a
// time, advancing whenever the consumer strobes shift_en.
module serializador_param #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] D,
  input  logic         shift_en,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [N-1:0]  shreg, next_shreg;
  logic [CW-1:0] cnt, next_cnt;
  logic [N-1:0]  shifted;

  // The last shift also runs, so the register is empty once the word completes.
  assign shifted = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      shreg <= next_shreg;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_shreg = shreg;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (load) begin
          next_shreg = D;
          next_cnt   = '0;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          next_shreg = shifted;
          if (cnt == LAST) begin
            next_cnt   = '0;
            next_state = DONE;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    busy       = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    sout       = 1'b0;
    case (state)
      IDLE:  ready = 1'b1;
      SHIFT: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        sout       = MSB_FIRST ? shreg[N-1] : shreg[0];
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: doc/serializador_param.md
SERIALIZADOR_PARAM -- requirements
Module: serializador_param

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the parallel word width in bits (N >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit N-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port load, input, 1 bit, a request to accept D for serialization.
REQ-006 The block SHALL have port D, input, N bits, the parallel word to send.
REQ-007 The block SHALL have port shift_en, input, 1 bit, a consumer advance strobe that presents the next bit when high.
REQ-008 The block SHALL have port ready, output, 1 bit, high when a load will be accepted.
REQ-009 The block SHALL have port sout, output, 1 bit, the current serial bit.
REQ-010 The block SHALL have port sout_valid, output, 1 bit, high when sout carries a data bit.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a word is being shifted.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit is consumed.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE the outputs SHALL be ready=1, busy=0, sout_valid=0, done=0 and sout=0.
REQ-015 On a rising edge with IDLE and load=1, D SHALL be captured into an internal N-bit shift register, the bit counter SHALL be set to 0 and the FSM SHALL enter SHIFT.
REQ-016 In IDLE with load=0 the FSM SHALL remain in IDLE and the shift register SHALL hold its value.
REQ-017 In SHIFT the outputs SHALL be ready=0, busy=1, sout_valid=1 and done=0.
REQ-018 In SHIFT, sout SHALL be the register MSB when MSB_FIRST=1 and the register LSB otherwise.
REQ-019 The first bit SHALL appear on sout in the cycle after the load edge, giving 1 cycle of latency.
REQ-020 In SHIFT with shift_en=1 and counter < N-1, the register SHALL shift by one position toward the output end, fill with 0, and increment the counter.
REQ-021 In SHIFT with shift_en=0, the register, counter and sout SHALL hold unchanged, with no timeout.
REQ-022 In SHIFT with shift_en=1 and counter = N-1, the FSM SHALL enter DONE.
REQ-023 A word SHALL therefore occupy exactly N shift_en-qualified SHIFT cycles.
REQ-024 The bit counter width SHALL be $clog2(N); the counter SHALL never wrap within a word.
REQ-025 In DONE the outputs SHALL be done=1, ready=0, busy=0, sout_valid=0 and sout=0.
REQ-026 DONE SHALL last exactly one cycle, after which the FSM SHALL return unconditionally to IDLE.
REQ-027 A load asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-028 The minimum spacing between accepted loads SHALL be N+2 cycles when shift_en is held high.
REQ-029 shift_en asserted in IDLE or DONE SHALL have no effect.

Reset
REQ-030 When reset=0 at a rising edge, the FSM SHALL go to IDLE and the shift register and counter SHALL clear to 0, regardless of load or shift_en.
REQ-031 On the cycle after a reset edge, the outputs SHALL be ready=1, busy=0, sout_valid=0, sout=0 and done=0.
REQ-032 Reset asserted mid-word SHALL abort the transfer without a done pulse, and the remaining bits SHALL be discarded.

Verification
REQ-033 Basic MSB-first send: with N=16 and MSB_FIRST=1, load D=16'hA5C3 with shift_en held at 1 -> sout = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on cycles 1..16 with sout_valid=1, done=1 on cycle 17, ready=1 on cycle 18.
REQ-034 LSB-first send: with MSB_FIRST=0, load D=16'h0001 -> sout=1 on cycle 1 and 0 on cycles 2..16.
REQ-035 Stall: hold shift_en=0 for 5 cycles after bit 3 -> bit 3 is held for 6 cycles, the stream is otherwise unchanged, and done is delayed by 5 cycles.
REQ-036 Load while busy: load D=16'hFFFF at cycle 8 of the 16'hA5C3 transfer -> the stream is unaffected and the FSM returns to IDLE with the register at 0.
REQ-037 Reset mid-word: drive reset=0 at cycle 6 -> next cycle ready=1, sout_valid=0, and no done pulse occurs.
REQ-038 Back-to-back: load 16'h8000 then load 16'h0001 at the first ready=1 cycle -> two complete streams separated by exactly one DONE cycle and one IDLE cycle.
